// File: rtl/showdown_pkg.sv
// Shared constants, types and saturating arithmetic helpers for the
// space-battle showdown ship logic.
package showdown_pkg;

  localparam int MAX_ACCEL    = 4;
  localparam int MAX_VEL      = 8;
  localparam int BOARD        = 64;
  localparam int MAX_ENERGY   = 80;
  localparam int RECHARGE     = 15;
  localparam int FIRE_COST    = 30;
  localparam int SHIELD_COST  = 25;
  localparam int CLOAK_COST   = 15;
  localparam int BULLET_SPEED = 9;
  localparam int BULLET_TIME  = 6;
  localparam int HIT_RADIUS   = 8;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } fire_dir_e;

  typedef struct packed {
    logic signed [7:0] x;
    logic signed [7:0] y;
    logic signed [4:0] vx;
    logic signed [4:0] vy;
    logic [7:0]        energy;
    logic              destroyed;
  } ship_state_t;

  function automatic int clamp_int(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Clamp the raw acceleration first, then the resulting velocity.
  function automatic logic signed [4:0] next_vel(input logic signed [4:0] v,
                                                 input logic signed [3:0] a);
    int s;
    s = int'(v) + clamp_int(int'(a), MAX_ACCEL);
    return 5'(clamp_int(s, MAX_VEL));
  endfunction

  function automatic logic beyond_board(input int c);
    return (c > BOARD) || (c < -BOARD);
  endfunction

  function automatic logic within_radius(input int bx, input int by,
                                         input int sx, input int sy);
    int dx;
    int dy;
    dx = bx - sx;
    dy = by - sy;
    return (dx <= HIT_RADIUS) && (dx >= -HIT_RADIUS) &&
           (dy <= HIT_RADIUS) && (dy >= -HIT_RADIUS);
  endfunction

  function automatic logic [7:0] recharge(input logic [7:0] e);
    int s;
    s = int'(e) + RECHARGE;
    if (s > MAX_ENERGY) s = MAX_ENERGY;
    return 8'(s);
  endfunction

endpackage

// File: rtl/ship_state_engine_if.sv
// Per-player step bus between the game controller (master) and the
// authoritative ship_state_engine (slave).
interface ship_state_engine_if #(parameter int NUM_SHIPS = 3);

  // step is a one-cycle strobe with no back-pressure: every cycle step=1 the
  // engine consumes all action inputs and the results appear the next cycle.
  logic                 step;
  logic signed [3:0]    x_a [NUM_SHIPS];
  logic signed [3:0]    y_a [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] attempt_fire;
  logic [NUM_SHIPS-1:0] attempt_shield;
  logic [NUM_SHIPS-1:0] attempt_cloak;
  logic [1:0]           fire_dir [NUM_SHIPS];
  logic signed [7:0]    enemy_bullet_x [NUM_SHIPS];
  logic signed [7:0]    enemy_bullet_y [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] enemy_bullet_active;

  logic signed [7:0]    x [NUM_SHIPS];
  logic signed [7:0]    y [NUM_SHIPS];
  logic [7:0]           energy [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] destroyed;
  logic [NUM_SHIPS-1:0] shielded;
  logic [NUM_SHIPS-1:0] cloaked;
  logic signed [7:0]    bullet_x [NUM_SHIPS];
  logic signed [7:0]    bullet_y [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] bullet_active;

  modport master (
    output step, x_a, y_a, attempt_fire, attempt_shield, attempt_cloak,
           fire_dir, enemy_bullet_x, enemy_bullet_y, enemy_bullet_active,
    input  x, y, energy, destroyed, shielded, cloaked,
           bullet_x, bullet_y, bullet_active
  );

  modport slave (
    input  step, x_a, y_a, attempt_fire, attempt_shield, attempt_cloak,
           fire_dir, enemy_bullet_x, enemy_bullet_y, enemy_bullet_active,
    output x, y, energy, destroyed, shielded, cloaked,
           bullet_x, bullet_y, bullet_active
  );

endinterface

// File: rtl/ship_bullet.sv
// One ship's bullet: spawns at the ship's new position, then flies in its
// latched direction until its lifetime runs out or it leaves the board.
module ship_bullet
  import showdown_pkg::*;
#(
  parameter bit MIRROR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              spawn,
  input  logic signed [7:0] spawn_x,
  input  logic signed [7:0] spawn_y,
  input  fire_dir_e         spawn_dir,
  output logic signed [7:0] bullet_x,
  output logic signed [7:0] bullet_y,
  output logic              bullet_active,
  output logic [2:0]        life
);

  fire_dir_e dir_q;
  int        dx;
  int        dy;
  int        next_x;
  int        next_y;
  logic      expire;

  // MIRROR flips only the horizontal component of the latched direction.
  always_comb begin
    dx = 0;
    dy = 0;
    case (dir_q)
      DIR_RIGHT: dx = MIRROR ? -BULLET_SPEED : BULLET_SPEED;
      DIR_LEFT:  dx = MIRROR ? BULLET_SPEED : -BULLET_SPEED;
      DIR_UP:    dy = BULLET_SPEED;
      DIR_DOWN:  dy = -BULLET_SPEED;
      default: begin
        dx = 0;
        dy = 0;
      end
    endcase
    next_x = int'(bullet_x) + dx;
    next_y = int'(bullet_y) + dy;
    expire = (life == 3'd1) || beyond_board(next_x) || beyond_board(next_y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
      life          <= '0;
      dir_q         <= DIR_RIGHT;
    end else if (step) begin
      if (spawn) begin
        bullet_x      <= spawn_x;
        bullet_y      <= spawn_y;
        bullet_active <= 1'b1;
        life          <= 3'(BULLET_TIME);
        dir_q         <= spawn_dir;
      end else if (bullet_active) begin
        bullet_x <= 8'(next_x);
        bullet_y <= 8'(next_y);
        life     <= expire ? 3'd0 : life - 3'd1;
        if (expire) bullet_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ship_state_engine.sv
// Authoritative per-player ship updater: physics, energy budget, own bullets
// and enemy-bullet hit detection, all advanced once per step strobe.
module ship_state_engine
  import showdown_pkg::*;
#(
  parameter int NUM_SHIPS = 3,
  parameter int START_X   = -40,
  parameter bit MIRROR    = 1'b0
) (
  input logic               clk,
  input logic               reset,
  ship_state_engine_if.slave bus
);

  for (genvar i = 0; i < NUM_SHIPS; i++) begin : g_ship
    localparam logic signed [7:0] X0 = 8'(MIRROR ? -START_X : START_X);
    localparam logic signed [7:0] Y0 = 8'((i - 1) * 20);

    ship_state_t          cur;
    ship_state_t          nxt;
    logic signed [4:0]    new_vx;
    logic signed [4:0]    new_vy;
    logic signed [8:0]    new_x;
    logic signed [8:0]    new_y;
    logic [7:0]           e_work;
    logic                 fire_ok;
    logic                 shield_ok;
    logic                 cloak_ok;
    logic                 shielded_q;
    logic                 cloaked_q;
    logic [NUM_SHIPS-1:0] near;
    logic                 hit_any;
    logic                 bullet_act;
    logic signed [7:0]    bullet_x_w;
    logic signed [7:0]    bullet_y_w;
    logic [2:0]           bullet_life;

    // Position is summed at 9 bits so a ship leaving the board is seen as such.
    assign new_vx = next_vel(cur.vx, bus.x_a[i]);
    assign new_vy = next_vel(cur.vy, bus.y_a[i]);
    assign new_x  = 9'(int'(cur.x) + int'(new_vx));
    assign new_y  = 9'(int'(cur.y) + int'(new_vy));

    for (genvar j = 0; j < NUM_SHIPS; j++) begin : g_hit
      assign near[j] = bus.enemy_bullet_active[j] &&
                       within_radius(int'(bus.enemy_bullet_x[j]),
                                     int'(bus.enemy_bullet_y[j]),
                                     int'(new_x), int'(new_y));
    end
    assign hit_any = |near;

    always_comb begin
      nxt       = cur;
      e_work    = cur.energy;
      fire_ok   = 1'b0;
      shield_ok = 1'b0;
      cloak_ok  = 1'b0;
      if (!cur.destroyed) begin
        fire_ok = bus.attempt_fire[i] && !bullet_act && (int'(e_work) >= FIRE_COST);
        if (fire_ok) e_work = e_work - 8'(FIRE_COST);
        shield_ok = bus.attempt_shield[i] && (int'(e_work) >= SHIELD_COST);
        if (shield_ok) e_work = e_work - 8'(SHIELD_COST);
        cloak_ok = bus.attempt_cloak[i] && (int'(e_work) >= CLOAK_COST);
        if (cloak_ok) e_work = e_work - 8'(CLOAK_COST);
        nxt.x         = new_x[7:0];
        nxt.y         = new_y[7:0];
        nxt.vx        = new_vx;
        nxt.vy        = new_vy;
        nxt.energy    = recharge(e_work);
        nxt.destroyed = beyond_board(int'(new_x)) || beyond_board(int'(new_y)) ||
                        (hit_any && !shield_ok);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cur        <= '{x: X0, y: Y0, vx: '0, vy: '0,
                        energy: 8'(MAX_ENERGY), destroyed: 1'b0};
        shielded_q <= 1'b0;
        cloaked_q  <= 1'b0;
      end else if (bus.step) begin
        cur        <= nxt;
        shielded_q <= shield_ok;
        cloaked_q  <= cloak_ok;
      end
    end

    // A bullet already in flight keeps going even after its ship is destroyed.
    ship_bullet #(.MIRROR(MIRROR)) u_bullet (
      .clk           (clk),
      .reset         (reset),
      .step          (bus.step),
      .spawn         (fire_ok),
      .spawn_x       (new_x[7:0]),
      .spawn_y       (new_y[7:0]),
      .spawn_dir     (fire_dir_e'(bus.fire_dir[i])),
      .bullet_x      (bullet_x_w),
      .bullet_y      (bullet_y_w),
      .bullet_active (bullet_act),
      .life          (bullet_life)
    );

    assign bus.x[i]             = cur.x;
    assign bus.y[i]             = cur.y;
    assign bus.energy[i]        = cur.energy;
    assign bus.destroyed[i]     = cur.destroyed;
    assign bus.shielded[i]      = shielded_q;
    assign bus.cloaked[i]       = cloaked_q;
    assign bus.bullet_x[i]      = bullet_x_w;
    assign bus.bullet_y[i]      = bullet_y_w;
    assign bus.bullet_active[i] = bullet_act && (bullet_life != 3'd0);
  end

endmodule

// File: tb/tb_ship_state_engine.sv
// Randomised and directed bench for ship_state_engine with a queue-based
// scoreboard fed by an integer reference model of the game rules.
module tb_ship_state_engine;

  localparam int NS        = 3;
  localparam int T_ACC     = 4;
  localparam int T_VEL     = 8;
  localparam int T_BOARD   = 64;
  localparam int T_EMAX    = 80;
  localparam int T_RECH    = 15;
  localparam int T_FIRE    = 30;
  localparam int T_SHIELD  = 25;
  localparam int T_CLOAK   = 15;
  localparam int T_BSPEED  = 9;
  localparam int T_BTIME   = 6;
  localparam int T_RADIUS  = 8;

  typedef struct packed {
    logic signed [7:0] x;
    logic signed [7:0] y;
    logic [7:0]        energy;
    logic              destroyed;
    logic              shielded;
    logic              cloaked;
    logic              bact;
    logic signed [7:0] bx;
    logic signed [7:0] by;
  } ship_snap_t;
  localparam int SW = $bits(ship_snap_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ship_state_engine_if #(.NUM_SHIPS(NS)) bus ();

  ship_state_engine #(.NUM_SHIPS(NS), .START_X(-40), .MIRROR(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // stimulus values
  int xa [NS], ya [NS], fd [NS], ebx [NS], eby [NS];
  bit af [NS], as_ [NS], ac [NS], eba [NS];

  // reference model state
  int m_x [NS], m_y [NS], m_vx [NS], m_vy [NS], m_en [NS];
  int m_bx [NS], m_by [NS], m_blife [NS], m_bdx [NS], m_bdy [NS];
  bit m_dead [NS], m_sh [NS], m_cl [NS], m_bact [NS];

  // scoreboard
  logic [NS*SW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : ((v < -lim) ? -lim : v);
  endfunction

  task automatic check(input string name, input int ship, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s ship%0d got=%0d expected=%0d t=%0t", name, ship, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = -40;  m_y[i] = (i - 1) * 20;
      m_vx[i] = 0;   m_vy[i] = 0;  m_en[i] = T_EMAX;
      m_dead[i] = 0; m_sh[i] = 0;  m_cl[i] = 0;
      m_bact[i] = 0; m_bx[i] = 0;  m_by[i] = 0; m_blife[i] = 0;
      m_bdx[i] = 0;  m_bdy[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NS; i++) begin
      bit f, s, c, hit;
      int nx, ny, e;
      f = 0; s = 0; c = 0; hit = 0;
      nx = m_x[i]; ny = m_y[i];
      if (!m_dead[i]) begin
        m_vx[i] = clampv(m_vx[i] + clampv(xa[i], T_ACC), T_VEL);
        m_vy[i] = clampv(m_vy[i] + clampv(ya[i], T_ACC), T_VEL);
        nx = m_x[i] + m_vx[i];
        ny = m_y[i] + m_vy[i];
        e = m_en[i];
        if (af[i] && !m_bact[i] && e >= T_FIRE) begin f = 1; e -= T_FIRE; end
        if (as_[i] && e >= T_SHIELD) begin s = 1; e -= T_SHIELD; end
        if (ac[i] && e >= T_CLOAK) begin c = 1; e -= T_CLOAK; end
        e = (e + T_RECH > T_EMAX) ? T_EMAX : e + T_RECH;
        for (int j = 0; j < NS; j++)
          if (eba[j] && iabs(ebx[j] - nx) <= T_RADIUS && iabs(eby[j] - ny) <= T_RADIUS) hit = 1;
        m_x[i] = nx; m_y[i] = ny; m_en[i] = e;
        if (iabs(nx) > T_BOARD || iabs(ny) > T_BOARD || (hit && !s)) m_dead[i] = 1;
      end
      m_sh[i] = s;
      m_cl[i] = c;
      if (f) begin
        m_bact[i] = 1; m_bx[i] = nx; m_by[i] = ny; m_blife[i] = T_BTIME;
        m_bdx[i] = (fd[i] == 0) ? T_BSPEED : ((fd[i] == 2) ? -T_BSPEED : 0);
        m_bdy[i] = (fd[i] == 3) ? T_BSPEED : ((fd[i] == 1) ? -T_BSPEED : 0);
      end else if (m_bact[i]) begin
        m_bx[i] += m_bdx[i];
        m_by[i] += m_bdy[i];
        m_blife[i]--;
        if (m_blife[i] == 0 || iabs(m_bx[i]) > T_BOARD || iabs(m_by[i]) > T_BOARD) m_bact[i] = 0;
      end
    end
  endtask

  function automatic logic [NS*SW-1:0] snapshot();
    logic [NS*SW-1:0] v;
    ship_snap_t s;
    v = '0;
    for (int i = 0; i < NS; i++) begin
      s.x = 8'(m_x[i]);  s.y = 8'(m_y[i]);  s.energy = 8'(m_en[i]);
      s.destroyed = m_dead[i]; s.shielded = m_sh[i]; s.cloaked = m_cl[i];
      s.bact = m_bact[i];
      s.bx = m_bact[i] ? 8'(m_bx[i]) : 8'sd0;
      s.by = m_bact[i] ? 8'(m_by[i]) : 8'sd0;
      v[i*SW +: SW] = s;
    end
    return v;
  endfunction

  // driver tasks
  task automatic clear_inputs();
    for (int i = 0; i < NS; i++) begin
      xa[i] = 0; ya[i] = 0; fd[i] = 0; ebx[i] = 0; eby[i] = 0;
      af[i] = 0; as_[i] = 0; ac[i] = 0; eba[i] = 0;
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NS; i++) begin
      int tgt;
      xa[i]  = int'($urandom_range(0, 15)) - 8;
      ya[i]  = int'($urandom_range(0, 15)) - 8;
      fd[i]  = int'($urandom_range(0, 3));
      af[i]  = ($urandom_range(0, 1) == 1);
      as_[i] = ($urandom_range(0, 2) == 0);
      ac[i]  = ($urandom_range(0, 2) == 0);
      eba[i] = ($urandom_range(0, 1) == 1);
      tgt    = int'($urandom_range(0, NS - 1));
      ebx[i] = m_x[tgt] + int'($urandom_range(0, 24)) - 12;
      eby[i] = m_y[tgt] + int'($urandom_range(0, 24)) - 12;
    end
  endtask

  task automatic do_cycle(input bit rst, input bit stp);
    reset    = rst;
    bus.step = stp;
    for (int i = 0; i < NS; i++) begin
      bus.x_a[i]                 = 4'(xa[i]);
      bus.y_a[i]                 = 4'(ya[i]);
      bus.fire_dir[i]            = 2'(fd[i]);
      bus.attempt_fire[i]        = af[i];
      bus.attempt_shield[i]      = as_[i];
      bus.attempt_cloak[i]       = ac[i];
      bus.enemy_bullet_x[i]      = 8'(ebx[i]);
      bus.enemy_bullet_y[i]      = 8'(eby[i]);
      bus.enemy_bullet_active[i] = eba[i];
    end
    @(posedge clk);
    if (rst) model_reset();
    else if (stp) model_step();
    exp_q.push_back(snapshot());
    @(negedge clk);
  endtask

  // monitor: outputs are registered, so each pushed snapshot is due on the
  // falling edge right after the clock edge that produced it
  logic [NS*SW-1:0] mon_e;
  ship_snap_t       mon_s;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int i = 0; i < NS; i++) begin
        mon_s = mon_e[i*SW +: SW];
        check("x",             i, int'(bus.x[i]),             int'(mon_s.x));
        check("y",             i, int'(bus.y[i]),             int'(mon_s.y));
        check("energy",        i, int'(bus.energy[i]),        int'(mon_s.energy));
        check("destroyed",     i, int'(bus.destroyed[i]),     int'(mon_s.destroyed));
        check("shielded",      i, int'(bus.shielded[i]),      int'(mon_s.shielded));
        check("cloaked",       i, int'(bus.cloaked[i]),       int'(mon_s.cloaked));
        check("bullet_active", i, int'(bus.bullet_active[i]), int'(mon_s.bact));
        if (mon_s.bact) begin
          check("bullet_x", i, int'(bus.bullet_x[i]), int'(mon_s.bx));
          check("bullet_y", i, int'(bus.bullet_y[i]), int'(mon_s.by));
        end
      end
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b1);

    // acceleration clamp: x_a=7 on ship 0 for three steps
    xa[0] = 7;
    repeat (3) do_cycle(1'b0, 1'b1);

    // fire + shield + cloak from full energy
    do_cycle(1'b1, 1'b0);
    clear_inputs();
    af[1] = 1; as_[1] = 1; ac[1] = 1; fd[1] = 3;
    do_cycle(1'b0, 1'b1);
    clear_inputs();
    do_cycle(1'b0, 1'b1);

    // bullet lifetime with fire held, including the refire after expiry
    do_cycle(1'b1, 1'b0);
    clear_inputs();
    af[0] = 1; fd[0] = 0;
    repeat (9) do_cycle(1'b0, 1'b1);

    // enemy bullet at the hit radius corner (hit) and one unit outside (miss)
    for (int sh = 0; sh < 2; sh++) begin
      do_cycle(1'b1, 1'b0);
      clear_inputs();
      eba[0] = 1; ebx[0] = m_x[2] + 8; eby[0] = m_y[2] - 8;
      eba[1] = 1; ebx[1] = m_x[1] - 9; eby[1] = m_y[1];
      as_[2] = (sh == 1);
      do_cycle(1'b0, 1'b1);
      clear_inputs();
      do_cycle(1'b0, 1'b1);
    end

    // drive ship 0 off the right edge and ship 2 off the bottom
    do_cycle(1'b1, 1'b0);
    clear_inputs();
    xa[0] = 4; ya[2] = -8;
    repeat (17) do_cycle(1'b0, 1'b1);

    // step=0 hold with toggling inputs, then reset together with step
    repeat (10) begin
      randomize_inputs();
      do_cycle(1'b0, 1'b0);
    end
    randomize_inputs();
    do_cycle(1'b1, 1'b1);

    // randomised play with occasional resets
    repeat (600) begin
      randomize_inputs();
      if ($urandom_range(0, 39) == 0) do_cycle(1'b1, 1'($urandom_range(0, 1)));
      else do_cycle(1'b0, ($urandom_range(0, 3) != 0));
    end

    clear_inputs();
    do_cycle(1'b0, 1'b0);
    @(negedge clk);
    check("queue_drained", 0, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
